// File: rtl/l1_buyruk_onbellek.sv
// l1_buyruk_onbellek: direct-mapped, blocking L1 instruction cache.
//
// Sits between the core fetch port and the lower-level instruction memory
// and serves one fetch at a time. Tag and valid bits are held in flops.
// A hit is answered from the local data array. A miss refills one whole
// block from memory, writes it into the line and forwards it to the core.
//
// Ports:
//   clk_i, rstn_i              clock (rising edge), async active-low reset
//   buyruk_istek_*             core fetch request (address, valid/ready)
//   buyruk_yanit_*             block returned to the core (data, valid/ready)
//   bellek_istek_*             block-aligned refill request to memory
//   bellek_yanit_*             refill data from memory
//   onbellek_gecersiz_i        one-cycle pulse that invalidates every line
//   isabet_sayac_o / iska_sayac_o  free-running 32-bit hit / miss counters

`ifndef ADRES_BIT
`define ADRES_BIT 32
`endif
`ifndef L1_BLOK_BIT
`define L1_BLOK_BIT 32
`endif

module l1_buyruk_onbellek #(
  parameter int unsigned SATIR_SAYISI = 16,
  parameter int unsigned ADRES_BIT    = `ADRES_BIT,
  parameter int unsigned L1_BLOK_BIT  = `L1_BLOK_BIT
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [ADRES_BIT-1:0]   buyruk_istek_adres_i,
  input  logic                   buyruk_istek_gecerli_i,
  output logic                   buyruk_istek_hazir_o,
  output logic [L1_BLOK_BIT-1:0] buyruk_yanit_veri_o,
  output logic                   buyruk_yanit_gecerli_o,
  input  logic                   buyruk_yanit_hazir_i,
  output logic [ADRES_BIT-1:0]   bellek_istek_adres_o,
  output logic                   bellek_istek_gecerli_o,
  input  logic                   bellek_istek_hazir_i,
  input  logic [L1_BLOK_BIT-1:0] bellek_yanit_veri_i,
  input  logic                   bellek_yanit_gecerli_i,
  output logic                   bellek_yanit_hazir_o,
  input  logic                   onbellek_gecersiz_i,
  output logic [31:0]            isabet_sayac_o,
  output logic [31:0]            iska_sayac_o
);

  localparam int unsigned INDEKS_BIT = $clog2(SATIR_SAYISI);
  localparam int unsigned OFSET_BIT  = $clog2(L1_BLOK_BIT / 8);
  localparam int unsigned ETIKET_BIT = ADRES_BIT - INDEKS_BIT - OFSET_BIT;
  localparam int unsigned BLOK_BIT   = ETIKET_BIT + INDEKS_BIT;

  typedef enum logic [2:0] {
    BOSTA,
    ARA,
    BELLEK_ISTEK,
    BELLEK_BEKLE,
    YANIT
  } durum_e;

  durum_e                  durum_q, durum_d;
  // Only {tag, index} of the fetch address is kept; the byte offset is
  // irrelevant because the whole block is returned.
  logic [BLOK_BIT-1:0]     blok_q, blok_d;
  logic [SATIR_SAYISI-1:0] gecerli_q, gecerli_d;
  logic [L1_BLOK_BIT-1:0]  yanit_q, yanit_d;
  logic [31:0]             isabet_q, isabet_d;
  logic [31:0]             iska_q, iska_d;
  logic [ETIKET_BIT-1:0]   etiket_q [SATIR_SAYISI];
  logic [L1_BLOK_BIT-1:0]  veri_q   [SATIR_SAYISI];

  logic                    dolum_yaz;
  logic [INDEKS_BIT-1:0]   indeks;
  logic [ETIKET_BIT-1:0]   etiket;
  logic                    isabet;
  logic                    unused_ofset;

  assign unused_ofset = ^buyruk_istek_adres_i[OFSET_BIT-1:0];

  assign indeks = blok_q[INDEKS_BIT-1:0];
  assign etiket = blok_q[BLOK_BIT-1 -: ETIKET_BIT];
  assign isabet = gecerli_q[indeks] && (etiket_q[indeks] == etiket);

  assign buyruk_istek_hazir_o   = (durum_q == BOSTA) && !onbellek_gecersiz_i;
  assign buyruk_yanit_gecerli_o = (durum_q == YANIT);
  assign buyruk_yanit_veri_o    = yanit_q;
  assign bellek_istek_gecerli_o = (durum_q == BELLEK_ISTEK);
  assign bellek_istek_adres_o   = (durum_q == BELLEK_ISTEK) ?
                                  {blok_q, {OFSET_BIT{1'b0}}} : '0;
  assign bellek_yanit_hazir_o   = (durum_q == BELLEK_BEKLE);
  assign isabet_sayac_o         = isabet_q;
  assign iska_sayac_o           = iska_q;

  always_comb begin
    durum_d   = durum_q;
    blok_d    = blok_q;
    gecerli_d = gecerli_q;
    yanit_d   = yanit_q;
    isabet_d  = isabet_q;
    iska_d    = iska_q;
    dolum_yaz = 1'b0;

    unique case (durum_q)
      BOSTA: begin
        if (buyruk_istek_gecerli_i && buyruk_istek_hazir_o) begin
          blok_d  = buyruk_istek_adres_i[ADRES_BIT-1:OFSET_BIT];
          durum_d = ARA;
        end
      end
      ARA: begin
        if (isabet) begin
          yanit_d  = veri_q[indeks];
          isabet_d = isabet_q + 32'd1;
          durum_d  = YANIT;
        end else begin
          iska_d  = iska_q + 32'd1;
          durum_d = BELLEK_ISTEK;
        end
      end
      BELLEK_ISTEK: begin
        if (bellek_istek_hazir_i) begin
          durum_d = BELLEK_BEKLE;
        end
      end
      BELLEK_BEKLE: begin
        if (bellek_yanit_gecerli_i) begin
          dolum_yaz         = 1'b1;
          gecerli_d[indeks] = 1'b1;
          yanit_d           = bellek_yanit_veri_i;
          durum_d           = YANIT;
        end
      end
      YANIT: begin
        if (buyruk_yanit_hazir_i) begin
          durum_d = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase

    // Invalidate wins over a coincident refill: the line is written but
    // stays invalid, while the refilled block still goes to the core.
    if (onbellek_gecersiz_i) begin
      gecerli_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q   <= BOSTA;
      blok_q    <= '0;
      gecerli_q <= '0;
      yanit_q   <= '0;
      isabet_q  <= '0;
      iska_q    <= '0;
    end else begin
      durum_q   <= durum_d;
      blok_q    <= blok_d;
      gecerli_q <= gecerli_d;
      yanit_q   <= yanit_d;
      isabet_q  <= isabet_d;
      iska_q    <= iska_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    if (dolum_yaz) begin
      etiket_q[indeks] <= etiket;
      veri_q[indeks]   <= bellek_yanit_veri_i;
    end
  end

endmodule

// File: tb/tb_l1_buyruk_onbellek.sv
module tb_l1_buyruk_onbellek;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] buyruk_istek_adres;
  logic        buyruk_istek_gecerli;
  logic        buyruk_istek_hazir;
  logic [31:0] buyruk_yanit_veri;
  logic        buyruk_yanit_gecerli;
  logic        buyruk_yanit_hazir;
  logic [31:0] bellek_istek_adres;
  logic        bellek_istek_gecerli;
  logic        bellek_istek_hazir;
  logic [31:0] bellek_yanit_veri;
  logic        bellek_yanit_gecerli;
  logic        bellek_yanit_hazir;
  logic        onbellek_gecersiz;
  logic [31:0] isabet_sayac;
  logic [31:0] iska_sayac;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l1_buyruk_onbellek #(
    .SATIR_SAYISI(16),
    .ADRES_BIT   (32),
    .L1_BLOK_BIT (32)
  ) dut (
    .clk_i                 (clk),
    .rstn_i                (rstn),
    .buyruk_istek_adres_i  (buyruk_istek_adres),
    .buyruk_istek_gecerli_i(buyruk_istek_gecerli),
    .buyruk_istek_hazir_o  (buyruk_istek_hazir),
    .buyruk_yanit_veri_o   (buyruk_yanit_veri),
    .buyruk_yanit_gecerli_o(buyruk_yanit_gecerli),
    .buyruk_yanit_hazir_i  (buyruk_yanit_hazir),
    .bellek_istek_adres_o  (bellek_istek_adres),
    .bellek_istek_gecerli_o(bellek_istek_gecerli),
    .bellek_istek_hazir_i  (bellek_istek_hazir),
    .bellek_yanit_veri_i   (bellek_yanit_veri),
    .bellek_yanit_gecerli_i(bellek_yanit_gecerli),
    .bellek_yanit_hazir_o  (bellek_yanit_hazir),
    .onbellek_gecersiz_i   (onbellek_gecersiz),
    .isabet_sayac_o        (isabet_sayac),
    .iska_sayac_o          (iska_sayac)
  );

  // Reference model: a 16-line direct-mapped table described per line.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  int unsigned exp_hit;
  int unsigned exp_miss;
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a / 4) % 16;
  endfunction

  function automatic logic [25:0] m_tg(input logic [31:0] a);
    return 26'(a / 64);
  endfunction

  function automatic logic [31:0] blk(input logic [31:0] a);
    return (a / 4) * 4;
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [31:0] b;
    b = blk(a);
    if (mem_ovr.exists(b)) return mem_ovr[b];
    return (b * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tg(a));
  endfunction

  function automatic logic [31:0] m_expect_data(input logic [31:0] a);
    if (m_hit(a)) return m_data[m_idx(a)];
    return mem_val(a);
  endfunction

  task automatic m_clear_valid();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic m_reset();
    m_clear_valid();
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  task automatic m_access(input logic [31:0] a, input bit inval);
    if (m_hit(a)) begin
      exp_hit++;
    end else begin
      exp_miss++;
      m_tag[m_idx(a)]   = m_tg(a);
      m_data[m_idx(a)]  = mem_val(a);
      m_valid[m_idx(a)] = 1'b1;
      if (inval) m_clear_valid();
    end
  endtask

  // Drives one fetch, acts as memory and core, and reports observations.
  task automatic fetch(input logic [31:0] a, input int req_stall,
                       input int rsp_stall, input int core_stall,
                       input bit inval_fill, output bit saw_req,
                       output logic [31:0] req_addr, output logic [31:0] data,
                       output int lat, output int unstable, output bit tmo);
    int rs = 0;
    int ps = 0;
    int cs = 0;
    saw_req  = 1'b0;
    req_addr = '0;
    data     = '0;
    lat      = 0;
    unstable = 0;
    tmo      = 1'b1;
    @(negedge clk);
    if (buyruk_istek_hazir !== 1'b1) unstable++;
    buyruk_istek_gecerli = 1'b1;
    buyruk_istek_adres   = a;
    @(negedge clk);
    buyruk_istek_gecerli = 1'b0;
    buyruk_istek_adres   = $urandom;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      bellek_istek_hazir   = 1'b0;
      bellek_yanit_gecerli = 1'b0;
      onbellek_gecersiz    = 1'b0;
      if (buyruk_yanit_gecerli) begin
        if (lat == 0) begin
          lat  = cyc;
          data = buyruk_yanit_veri;
        end else if (buyruk_yanit_veri !== data) begin
          unstable++;
        end
        if (buyruk_istek_hazir !== 1'b0) unstable++;
        if (cs == core_stall) begin
          buyruk_yanit_hazir = 1'b1;
          @(negedge clk);
          buyruk_yanit_hazir = 1'b0;
          tmo = 1'b0;
          break;
        end
        cs++;
      end else if (bellek_istek_gecerli) begin
        if (!saw_req) begin
          saw_req  = 1'b1;
          req_addr = bellek_istek_adres;
        end else if (bellek_istek_adres !== req_addr) begin
          unstable++;
        end
        if (rs == req_stall) bellek_istek_hazir = 1'b1;
        else rs++;
      end else if (bellek_yanit_hazir) begin
        if (ps == rsp_stall) begin
          bellek_yanit_gecerli = 1'b1;
          bellek_yanit_veri    = mem_val(req_addr);
          if (inval_fill) onbellek_gecersiz = 1'b1;
        end else begin
          ps++;
        end
      end
      @(negedge clk);
    end
    bellek_istek_hazir   = 1'b0;
    bellek_yanit_gecerli = 1'b0;
    onbellek_gecersiz    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({buyruk_istek_hazir, buyruk_yanit_gecerli, bellek_istek_gecerli,
         bellek_yanit_hazir} !== 4'b1000) begin
      errors++;
      $display("FAIL %s flags: got %b want 1000", tag,
               {buyruk_istek_hazir, buyruk_yanit_gecerli, bellek_istek_gecerli,
                bellek_yanit_hazir});
    end
    checks++;
    if ({buyruk_yanit_veri, bellek_istek_adres, isabet_sayac, iska_sayac} !== 128'd0) begin
      errors++;
      $display("FAIL %s values: veri=%h adres=%h isabet=%0d iska=%0d want all 0",
               tag, buyruk_yanit_veri, bellek_istek_adres, isabet_sayac, iska_sayac);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    check_reset_outputs("reset_during");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_after");
    m_reset();
  endtask

  task automatic test_cold_miss();
    bit s; logic [31:0] ra, d; int l, u; bit t;
    mem_ovr[32'h0000_0004] = 32'h0010_8093;
    fetch(32'h0000_0004, 0, 0, 0, 1'b0, s, ra, d, l, u, t);
    m_access(32'h0000_0004, 1'b0);
    checks++;
    if (t || s !== 1'b1 || ra !== 32'h0000_0004) begin
      errors++;
      $display("FAIL cold_req: tmo=%0b req=%0b adres=%h want req=1 adres=00000004", t, s, ra);
    end
    checks++;
    if (d !== 32'h0010_8093 || l != 4) begin
      errors++;
      $display("FAIL cold_data: got %h lat %0d want 00108093 lat 4", d, l);
    end
    checks++;
    if (iska_sayac !== 32'd1 || isabet_sayac !== 32'd0) begin
      errors++;
      $display("FAIL cold_cnt: iska=%0d isabet=%0d want 1 0", iska_sayac, isabet_sayac);
    end
  endtask

  task automatic test_hit();
    bit s; logic [31:0] ra, d; int l, u; bit t;
    fetch(32'h0000_0004, 0, 0, 0, 1'b0, s, ra, d, l, u, t);
    m_access(32'h0000_0004, 1'b0);
    checks++;
    if (t || s !== 1'b0 || l != 2 || d !== 32'h0010_8093) begin
      errors++;
      $display("FAIL hit: tmo=%0b memreq=%0b lat=%0d data=%h want 0 0 2 00108093", t, s, l, d);
    end
    checks++;
    if (isabet_sayac !== 32'd1 || iska_sayac !== 32'd1) begin
      errors++;
      $display("FAIL hit_cnt: isabet=%0d iska=%0d want 1 1", isabet_sayac, iska_sayac);
    end
  endtask

  task automatic test_conflict();
    bit s; logic [31:0] ra, d; int l, u; bit t;
    logic [31:0] seq [3];
    seq[0] = 32'h04; seq[1] = 32'h44; seq[2] = 32'h04;
    mem_ovr[32'h0000_0044] = 32'hfe20_9ee3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fetch(seq[i], 0, 0, 0, 1'b0, s, ra, d, l, u, t);
      checks++;
      if (t || s !== 1'b1 || ra !== seq[i] || d !== mem_val(seq[i])) begin
        errors++;
        $display("FAIL conflict_%0d: req=%0b adres=%h data=%h want 1 %h %h",
                 i, s, ra, d, seq[i], mem_val(seq[i]));
      end
      m_access(seq[i], 1'b0);
    end
    checks++;
    if (iska_sayac !== 32'd3 || isabet_sayac !== 32'd0) begin
      errors++;
      $display("FAIL conflict_cnt: iska=%0d isabet=%0d want 3 0", iska_sayac, isabet_sayac);
    end
  endtask

  task automatic test_backpressure();
    bit s; logic [31:0] ra, d; int l, u; bit t;
    fetch(32'h0000_0100, 3, 0, 5, 1'b0, s, ra, d, l, u, t);
    m_access(32'h0000_0100, 1'b0);
    checks++;
    if (t || u != 0) begin
      errors++;
      $display("FAIL bp_stable: tmo=%0b unstable=%0d want 0 0", t, u);
    end
    checks++;
    if (s !== 1'b1 || ra !== 32'h0000_0100 || d !== mem_val(32'h100) || l != 7) begin
      errors++;
      $display("FAIL bp_data: adres=%h data=%h lat=%0d want 00000100 %h 7",
               ra, d, l, mem_val(32'h100));
    end
  endtask

  task automatic test_invalidate_refill();
    bit s; logic [31:0] ra, d; int l, u; bit t;
    mem_ovr[32'h0000_0008] = 32'h0020_0113;
    fetch(32'h0000_0008, 0, 1, 0, 1'b1, s, ra, d, l, u, t);
    m_access(32'h0000_0008, 1'b1);
    checks++;
    if (t || s !== 1'b1 || d !== 32'h0020_0113) begin
      errors++;
      $display("FAIL inv_fill: req=%0b data=%h want 1 00200113", s, d);
    end
    fetch(32'h0000_0008, 0, 0, 0, 1'b0, s, ra, d, l, u, t);
    m_access(32'h0000_0008, 1'b0);
    checks++;
    if (t || s !== 1'b1 || iska_sayac !== exp_miss) begin
      errors++;
      $display("FAIL inv_fill_again: req=%0b iska=%0d want 1 %0d", s, iska_sayac, exp_miss);
    end
  endtask

  task automatic test_invalidate_idle();
    bit s; logic [31:0] ra, d; int l, u; bit t;
    fetch(32'h0000_0020, 0, 0, 0, 1'b0, s, ra, d, l, u, t);
    m_access(32'h0000_0020, 1'b0);
    @(negedge clk);
    onbellek_gecersiz    = 1'b1;
    buyruk_istek_gecerli = 1'b1;
    buyruk_istek_adres   = 32'h0000_0020;
    #1;
    checks++;
    if (buyruk_istek_hazir !== 1'b0) begin
      errors++;
      $display("FAIL inv_idle_hazir: got %b want 0", buyruk_istek_hazir);
    end
    @(negedge clk);
    onbellek_gecersiz    = 1'b0;
    buyruk_istek_gecerli = 1'b0;
    m_clear_valid();
    fetch(32'h0000_0020, 0, 0, 0, 1'b0, s, ra, d, l, u, t);
    m_access(32'h0000_0020, 1'b0);
    checks++;
    if (t || s !== 1'b1 || d !== mem_val(32'h20) || iska_sayac !== exp_miss) begin
      errors++;
      $display("FAIL inv_idle_miss: req=%0b data=%h iska=%0d want 1 %h %0d",
               s, d, iska_sayac, mem_val(32'h20), exp_miss);
    end
  endtask

  task automatic test_random();
    bit s; logic [31:0] ra, d; int l, u; bit t;
    logic [31:0] a;
    bit hit, inv;
    int rq, rp;
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        onbellek_gecersiz = 1'b1;
        #1;
        checks++;
        if (buyruk_istek_hazir !== 1'b0) begin
          errors++;
          $display("FAIL rnd_inv_hazir[%0d]: got %b want 0", n, buyruk_istek_hazir);
        end
        @(negedge clk);
        onbellek_gecersiz = 1'b0;
        m_clear_valid();
      end
      a   = ($urandom_range(0, 2) * 64) + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      rq  = $urandom_range(0, 2);
      rp  = $urandom_range(0, 2);
      inv = ($urandom_range(0, 7) == 0);
      hit = m_hit(a);
      fetch(a, rq, rp, $urandom_range(0, 3), inv, s, ra, d, l, u, t);
      checks++;
      if (t || u != 0 || s !== !hit || l != (hit ? 2 : 4 + rq + rp)) begin
        errors++;
        $display("FAIL rnd_flow[%0d] a=%h: tmo=%0b unstable=%0d memreq=%0b lat=%0d want hit=%0b",
                 n, a, t, u, s, l, hit);
      end
      checks++;
      if (d !== m_expect_data(a) || (!hit && ra !== blk(a))) begin
        errors++;
        $display("FAIL rnd_data[%0d] a=%h: data=%h adres=%h want %h %h",
                 n, a, d, ra, m_expect_data(a), blk(a));
      end
      m_access(a, inv);
      checks++;
      if (isabet_sayac !== exp_hit || iska_sayac !== exp_miss) begin
        errors++;
        $display("FAIL rnd_cnt[%0d]: isabet=%0d iska=%0d want %0d %0d",
                 n, isabet_sayac, iska_sayac, exp_hit, exp_miss);
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    bit s; logic [31:0] ra, d; int l, u; bit t;
    bit reached = 1'b0;
    logic [31:0] a = 32'h8000_0010;
    @(negedge clk);
    buyruk_istek_gecerli = 1'b1;
    buyruk_istek_adres   = a;
    @(negedge clk);
    buyruk_istek_gecerli = 1'b0;
    bellek_istek_hazir   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bellek_yanit_hazir) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bellek_istek_hazir = 1'b0;
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL rst_mid_reach: refill wait state not reached within 20 cycles");
    end
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    bellek_yanit_gecerli = 1'b1;
    bellek_yanit_veri    = 32'hdead_beef;
    @(negedge clk);
    rstn = 1'b1;
    m_reset();
    @(negedge clk);
    checks++;
    if ({bellek_yanit_hazir, buyruk_yanit_gecerli, buyruk_istek_hazir} !== 3'b001) begin
      errors++;
      $display("FAIL rst_mid_late: yanit_hazir=%b yanit_gecerli=%b istek_hazir=%b want 0 0 1",
               bellek_yanit_hazir, buyruk_yanit_gecerli, buyruk_istek_hazir);
    end
    bellek_yanit_gecerli = 1'b0;
    fetch(a, 0, 0, 0, 1'b0, s, ra, d, l, u, t);
    m_access(a, 1'b0);
    checks++;
    if (t || s !== 1'b1 || ra !== blk(a) || d !== mem_val(a) || iska_sayac !== 32'd1) begin
      errors++;
      $display("FAIL rst_mid_refetch: req=%0b adres=%h data=%h iska=%0d want 1 %h %h 1",
               s, ra, d, iska_sayac, blk(a), mem_val(a));
    end
  endtask

  initial begin
    rstn                 = 1'b0;
    buyruk_istek_adres   = '0;
    buyruk_istek_gecerli = 1'b0;
    buyruk_yanit_hazir   = 1'b0;
    bellek_istek_hazir   = 1'b0;
    bellek_yanit_veri    = '0;
    bellek_yanit_gecerli = 1'b0;
    onbellek_gecersiz    = 1'b0;
    m_reset();
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_backpressure();
    test_invalidate_refill();
    test_invalidate_idle();
    test_random();
    test_reset_mid_refill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
